// File: rtl/axi_fc_stream_tx_if.sv
// Result-byte input and AXI4-Stream output bundle for the FC result streamer.
// The master side is the streamer; the slave side is the FC core plus the stream sink.
interface axi_fc_stream_tx_if #(
  parameter int AXI_BUS_WIDTH = 32
);
  logic                     res_valid;
  logic [7:0]               res_data;
  logic                     res_ready;
  logic                     m_axis_valid;
  logic [AXI_BUS_WIDTH-1:0] m_axis_data;
  logic                     m_axis_ready;
  logic                     m_axis_last;
  logic [3:0]               m_axis_keep;

  modport master (
    input  res_valid,
    input  res_data,
    input  m_axis_ready,
    output res_ready,
    output m_axis_valid,
    output m_axis_data,
    output m_axis_last,
    output m_axis_keep
  );

  modport slave (
    output res_valid,
    output res_data,
    output m_axis_ready,
    input  res_ready,
    input  m_axis_valid,
    input  m_axis_data,
    input  m_axis_last,
    input  m_axis_keep
  );
endinterface

// File: rtl/axi_fc_stream_tx.sv
// Packs FC result bytes little-endian into 32-bit AXI4-Stream beats.
// One frame per start; the last beat carries a partial keep when needed.
module axi_fc_stream_tx #(
  parameter int AXI_BUS_WIDTH = 32,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic                 busy,
  output logic                 done,
  axi_fc_stream_tx_if.master   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PACK = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]               r_state;
  logic [LEN_WIDTH-1:0]     r_rem;
  logic [1:0]               r_idx;
  logic [AXI_BUS_WIDTH-1:0] r_pack;
  logic [3:0]               r_keep;

  logic                     w_idle;
  logic                     w_pack;
  logic                     w_send;
  logic                     w_start;
  logic                     w_last_byte;
  logic [3:0]               w_lane;
  logic [AXI_BUS_WIDTH-1:0] w_byte_sh;

  assign w_idle      = (r_state == S_IDLE);
  assign w_pack      = (r_state == S_PACK);
  assign w_send      = (r_state == S_SEND);
  assign w_start     = w_idle && start && (frame_len != '0);
  assign w_last_byte = (r_idx == 2'd3) || (r_rem == LEN_WIDTH'(1));
  assign w_lane      = 4'b0001 << r_idx;
  assign w_byte_sh   = AXI_BUS_WIDTH'(bus.res_data) << {r_idx, 3'b000};

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
      r_pack  <= '0;
      r_keep  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rem   <= frame_len;
            r_idx   <= '0;
            r_pack  <= '0;
            r_keep  <= '0;
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          if (bus.res_valid) begin
            r_pack <= r_pack | w_byte_sh;
            r_keep <= r_keep | w_lane;
            r_idx  <= r_idx + 2'd1;
            r_rem  <= r_rem - LEN_WIDTH'(1);
            if (w_last_byte) r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.m_axis_ready) begin
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end else begin
              r_pack  <= '0;
              r_keep  <= '0;
              r_idx   <= '0;
              r_state <= S_PACK;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat fields are gated so they read zero whenever no beat is offered.
  assign bus.res_ready    = w_pack;
  assign bus.m_axis_valid = w_send;
  assign bus.m_axis_data  = w_send ? r_pack : '0;
  assign bus.m_axis_keep  = w_send ? r_keep : 4'b0000;
  assign bus.m_axis_last  = w_send && (r_rem == '0);
  assign busy             = !w_idle;
  assign done             = (r_state == S_DONE);

endmodule

// File: tb/tb_axi_fc_stream_tx.sv
// Randomized self-checking bench for axi_fc_stream_tx.
// Expected beats are built from the frame byte list, four bytes per beat.
module tb_axi_fc_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] fb [0:255];

  axi_fc_stream_tx_if #(.AXI_BUS_WIDTH(32)) bus ();

  axi_fc_stream_tx #(
    .AXI_BUS_WIDTH(32),
    .LEN_WIDTH(16)
  ) dut (
    .axi_clk    (clk),
    .axi_reset_n(rst_n),
    .start      (start),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, bus.m_axis_valid, 1'b0);
    chk({tag, "_data"}, bus.m_axis_data, 32'h0);
    chk({tag, "_keep"}, bus.m_axis_keep, 4'h0);
    chk({tag, "_last"}, bus.m_axis_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic run_frame(input int len, input int p_val, input int p_rdy,
                           input int stall_in, input bit poke);
    int ptr;
    int bi;
    int nbeat;
    int cyc;
    int stall;
    bit fin;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    ptr   = 0;
    bi    = 0;
    cyc   = 0;
    fin   = 0;
    stall = stall_in;
    nbeat = (len + 3) / 4;
    @(negedge clk);
    start = 1'b1;
    frame_len = 16'(len);
    bus.res_valid = 1'b0;
    bus.m_axis_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    frame_len = 16'($urandom);
    #1;
    chk("busy_on", busy, 1'b1);
    while (!fin && cyc < 2000) begin
      bus.res_valid = (ptr < len) ? ($urandom_range(99) < p_val)
                                  : 1'($urandom_range(1));
      bus.res_data = (ptr < len && bus.res_valid) ? fb[ptr] : 8'($urandom);
      bus.m_axis_ready = (stall > 0) ? 1'b0 : ($urandom_range(99) < p_rdy);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      frame_len = 16'($urandom);
      #1;
      if (bus.m_axis_valid) begin
        ed = '0;
        ek = '0;
        for (int j = 0; j < 4; j++) begin
          if (4 * bi + j < len) begin
            ed[8*j +: 8] = fb[4*bi+j];
            ek[j] = 1'b1;
          end
        end
        el = (bi == nbeat - 1);
        chk("beat_data", bus.m_axis_data, ed);
        chk("beat_keep", bus.m_axis_keep, ek);
        chk("beat_last", bus.m_axis_last, el);
        chk("rdy_in_send", bus.res_ready, 1'b0);
        if (stall > 0) stall--;
        if (bus.m_axis_ready) begin
          bi++;
          if (el) fin = 1;
        end
      end
      if (bus.res_valid && bus.res_ready) ptr++;
      cyc++;
      @(negedge clk);
    end
    if (!fin) chk("timeout", 1'b1, 1'b0);
    start = 1'b0;
    bus.res_valid = 1'b0;
    bus.m_axis_ready = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b1);
    chk("bytes", 64'(ptr), 64'(len));
    chk("beats", 64'(bi), 64'(nbeat));
    @(negedge clk);
    #1;
    chk_quiet("after_done");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    frame_len = '0;
    bus.res_valid = 1'b0;
    bus.res_data = '0;
    bus.m_axis_ready = 1'b0;
    #12;
    chk_quiet("reset");
    chk("reset_rdy", bus.res_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
    run_frame(8, 100, 100, 0, 0);
    run_frame(5, 100, 100, 0, 0);
    run_frame(8, 100, 100, 10, 0);

    @(negedge clk);
    start = 1'b1;
    frame_len = 16'd0;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk_quiet("zero_len");
      chk("zero_len_rdy", bus.res_ready, 1'b0);
    end
    start = 1'b0;
    bus.res_valid = 1'b0;

    for (int i = 0; i < 12; i++) fb[i] = 8'($urandom);
    run_frame(12, 70, 60, 0, 1);

    @(negedge clk);
    start = 1'b1;
    frame_len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.res_valid = 1'b1;
      bus.res_data = 8'(i + 1);
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_rdy", bus.res_ready, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_rdy", bus.res_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_axis_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.res_valid = 1'($urandom_range(1));
      bus.res_data = 8'($urandom);
      @(negedge clk);
      #1;
      chk_quiet("post_rst");
    end
    bus.res_valid = 1'b0;
    fb[0] = 8'hAA;
    fb[1] = 8'hBB;
    fb[2] = 8'hCC;
    fb[3] = 8'hDD;
    run_frame(4, 100, 100, 0, 0);

    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      run_frame(len, $urandom_range(100, 30), $urandom_range(100, 30),
                $urandom_range(3), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_fc_stream_tx.md
AXI_FC_STREAM_TX -- requirements
Module: axi_fc_stream_tx

Interface
REQ-001 SHALL have parameter AXI_BUS_WIDTH, default 32, stream data width in bits (fixed 32; keep is 4 bits).
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the frame byte count.
REQ-003 SHALL have port axi_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port axi_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port frame_len  input  LEN_WIDTH  number of result bytes in the frame, latched on accepted start.
REQ-007 SHALL have port busy  output  1  high from accepted start until the done cycle inclusive.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last beat handshake.
REQ-009 SHALL have port res_valid  input  1  FC core result byte valid.
REQ-010 SHALL have port res_data  input  8  FC core result byte.
REQ-011 SHALL have port res_ready  output  1  streamer accepts res_data this cycle.
REQ-012 SHALL have port m_axis_valid  output  1  AXI4-S master valid.
REQ-013 SHALL have port m_axis_data  output  AXI_BUS_WIDTH  AXI4-S master data.
REQ-014 SHALL have port m_axis_ready  input  1  downstream ready.
REQ-015 SHALL have port m_axis_last  output  1  final beat of frame.
REQ-016 SHALL have port m_axis_keep  output  4  byte-lane enables of current beat.

Function
REQ-017 SHALL implement states IDLE, PACK, SEND, DONE.
REQ-018 IDLE: start=1 with frame_len!=0 -> latch frame_len into remaining-byte counter, clear lane index and pack register, go PACK; start with frame_len=0 ignored (no beat, busy and done stay 0).
REQ-019 PACK: res_ready=1; byte accepted on res_valid&res_ready; written to lane idx (bits 8*idx+7:8*idx, little-endian), keep bit idx set, idx+1, remaining-1.
REQ-020 PACK -> SEND when the accepted byte fills lane 3 or is the last frame byte (remaining=1); m_axis_valid=1 the cycle after that acceptance.
REQ-021 SEND: res_ready=0; m_axis_valid=1; m_axis_last=1 iff remaining=0; unused lanes data=0, keep=0.
REQ-022 SEND: m_axis_data/keep/last SHALL stay stable while m_axis_valid=1 and m_axis_ready=0; valid never drops before handshake.
REQ-023 SEND handshake (valid&ready): last=1 -> DONE; else clear pack register/keep, idx=0, -> PACK.
REQ-024 DONE: done=1 one cycle, busy=1, -> IDLE next cycle.
REQ-025 start asserted outside IDLE SHALL be ignored; frame_len changes after latch SHALL have no effect.
REQ-026 res_ready SHALL be 0 in IDLE, SEND, DONE; res_valid there SHALL have no effect.
REQ-027 Beat count per frame SHALL equal ceil(frame_len/4); last-beat keep = 0xF if frame_len%4=0 else (1<<(frame_len%4))-1.
REQ-028 m_axis_valid SHALL not depend combinationally on m_axis_ready.

Reset
REQ-029 axi_reset_n=0 SHALL force immediately: state IDLE, busy=0, done=0, res_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_keep=0, m_axis_data=0, counters 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no beat emitted after release until a new start.

Verification
REQ-031 frame_len=8, bytes 0x01..0x08, m_axis_ready=1 -> beats 0x04030201 keep 0xF last 0, then 0x08070605 keep 0xF last 1; done one cycle after second handshake.
REQ-032 frame_len=5, bytes 0x01..0x05 -> beat2 data 0x00000005 keep 0x1 last 1; exactly 2 beats.
REQ-033 m_axis_ready=0 for 10 cycles during SEND -> data/keep/last/valid unchanged, res_ready=0 throughout; handshake on ready=1.
REQ-034 start with frame_len=0 -> no beat, busy=0, done=0; start pulsed while busy -> ignored, frame completes unchanged.
REQ-035 axi_reset_n low after 3 of 8 bytes -> all outputs 0 asynchronously; after release, frame_len=4 bytes 0xAA..0xDD -> single beat 0xDDCCBBAA keep 0xF last 1.
REQ-036 res_valid toggling randomly, m_axis_ready random -> received byte stream equals sent bytes, beat count = ceil(frame_len/4).
